// File: rtl/dtype_mem_ctrl_if.sv
// Handshake bundle for dtype_mem_ctrl: control-unit side (start/operands/
// busy/done/err/rdata) and data-memory side (req/we/addr/wdata/ack/rdata).
interface dtype_mem_ctrl_if;
  logic        start;
  logic        is_store;
  logic [63:0] base;
  logic [8:0]  daddr9;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output start, is_store, base, daddr9, wdata,
    output mem_ack, mem_rdata,
    input  busy, done, err, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  start, is_store, base, daddr9, wdata,
    input  mem_ack, mem_rdata,
    output busy, done, err, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dtype_mem_ctrl.sv
// LEGv8 LDUR/STUR sequencer: base + sext(DAddr9), one req/ack to data memory.
// Ports: clk, reset (sync, active-high), bus (dtype_mem_ctrl_if.slave).
// Param TIMEOUT (1..255): REQ cycles without ack before abort with err.
// Macro DTYPE_ALIGN_CHECK_EN: misaligned address skips REQ, done with err.
module dtype_mem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic            clk,
  input logic            reset,
  dtype_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter value seen in the last allowed REQ cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        st_q;
  logic [63:0] base_q;
  logic [8:0]  d9_q;
  logic [63:0] wd_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [63:0] rdata_q;
  logic        req_q;
  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] mwd_q;
  logic [63:0] addr_d;
  logic        misal;

  assign addr_d = base_q + {{55{d9_q[8]}}, d9_q};

`ifdef DTYPE_ALIGN_CHECK_EN
  assign misal = |addr_d[2:0];
`else
  assign misal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= 1'b0;
      base_q  <= '0;
      d9_q    <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      mwd_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            st_q    <= bus.is_store;
            base_q  <= bus.base;
            d9_q    <= bus.daddr9;
            wd_q    <= bus.wdata;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          addr_q <= addr_d;
          if (misal) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            req_q   <= 1'b1;
            we_q    <= st_q;
            mwd_q   <= wd_q;
            state_q <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.mem_ack || cnt_q == CNT_LAST) begin
            if (bus.mem_ack && !st_q) begin
              rdata_q <= bus.mem_rdata;
            end
            err_q   <= !bus.mem_ack;
            done_q  <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            mwd_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mwd_q;

endmodule

// File: doc/dtype_mem_ctrl.md
# dtype_mem_ctrl

Sequencer for LEGv8 D-type memory instructions (LDUR/STUR) in the multi-cycle datapath. It latches the base register and the 9-bit DAddr9 field, sign-extends DAddr9 to 64 bits, and forms the effective address. It then drives a single-outstanding req/ack transaction to data memory and returns load data with a one-cycle completion pulse. It sits between the control unit and the data-memory port.

## Interface
- TIMEOUT, default 15: maximum REQ cycles without `mem_ack` before abort; legal range 1..255.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  begin operation; sampled only in IDLE
- is_store  in  1  1 = STUR, 0 = LDUR
- base  in  64  Rn value
- daddr9  in  9  signed DAddr9 offset
- wdata  in  64  store data (Rt)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with `done`: timeout, or misalignment when enabled
- rdata  out  64  load data; holds until the next load completes
- mem_req  out  1  memory request
- mem_we  out  1  write enable, valid with `mem_req`
- mem_addr  out  64  effective address
- mem_wdata  out  64  store data
- mem_ack  in  1  memory completion; sampled only in REQ
- mem_rdata  in  64  read data, valid with `mem_ack`

## Operation
- Reset value of every output is 0, including `rdata` and `mem_addr`. Reset also forces IDLE and clears the timeout counter.
- States: IDLE, CALC, REQ, DONE.
- IDLE to CALC: on `start`. Latch `is_store`, `base`, `daddr9` and `wdata` at that edge.
- CALC: register `mem_addr = base + {{55{daddr9[8]}}, daddr9}` as an unsigned 64-bit sum. Wrap is modulo 2^64; no overflow flag. Then go to REQ.
- REQ: assert `mem_req`; `mem_we = is_store`; `mem_wdata = wdata`. Hold all three stable until exit. Increment the counter each REQ cycle.
- REQ exit on `mem_ack`: if load, capture `mem_rdata` into `rdata`. Go to DONE with err = 0.
- REQ exit on timeout: after TIMEOUT REQ cycles with no `mem_ack`, go to DONE with err = 1. `rdata` is unchanged.
- DONE: `done` = 1 for exactly one cycle, then IDLE. The counter is cleared.
- `start` while busy is ignored, with no queuing.
- `mem_ack` outside REQ is ignored.
- `mem_req`, `mem_we` and `mem_wdata` are 0 outside REQ. `mem_addr` holds its last value.
- `err` is 0 whenever `done` is 0.
- Reset asserted mid-operation: IDLE on the next edge, all outputs 0. The abandoned transaction produces no `done`.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: CALC; `busy` = 1.
- Cycle 2: first REQ cycle, with `mem_addr` valid.
- Ack in REQ cycle k (k ≥ 2): `done` and `rdata` are valid at cycle k+1.
- Minimum latency, start to done: 3 cycles.
- Timeout: REQ covers cycles 2..TIMEOUT+1; `done` with err = 1 at cycle TIMEOUT+2.
- Back-to-back operation: `start` may be accepted in the cycle immediately after DONE.

## Configuration
- `DTYPE_ALIGN_CHECK_EN` defined:
  - In CALC, if the computed address has bits [2:0] ≠ 0, skip REQ and go directly to DONE with err = 1.
  - `mem_req` never asserts for that operation.
  - `mem_addr` still shows the computed address.
- Not defined: no alignment check; every address is issued to memory.

## Test plan
- Load, base = 0x100, daddr9 = 9'h1F8 (−8), ack in first REQ cycle with mem_rdata = 0xDEADBEEF -> mem_addr = 0xF8, mem_we = 0, done at cycle 3, rdata = 0xDEADBEEF, err = 0.
- Store, base = 0x1000, daddr9 = 9'h008, wdata = 0x1234, ack delayed 4 cycles -> mem_addr = 0x1008, mem_we = 1, mem_wdata = 0x1234 held 5 REQ cycles, done at cycle 7, rdata unchanged.
- Wrap, base = 0, daddr9 = 9'h100 (−256) -> mem_addr = 0xFFFF_FFFF_FFFF_FF00; `start` pulsed again during REQ is ignored.
- Timeout, TIMEOUT = 15, never ack -> mem_req high cycles 2..16, done with err = 1 at cycle 17, mem_req 0 afterwards.
- Reset asserted in the third REQ cycle -> next edge all outputs 0, state IDLE, no done; a new load then completes normally.
- With `DTYPE_ALIGN_CHECK_EN`, base = 0x100, daddr9 = 9'h004 -> mem_req never asserts, done with err = 1 at cycle 2. Without the macro -> mem_addr = 0x104 is issued normally.
